// File: rtl/spike_enc_pkg.sv
// Shared configuration, types and the timing-fit check for the spike encoder.
package spike_enc_pkg;

    localparam int unsigned P                  = 64;
    localparam int unsigned VRES               = 3;
    localparam int unsigned PULSE_WIDTH        = 8;
    localparam int unsigned GAMMA_CYCLE_LENGTH = 18;

    localparam int unsigned CNT_W = $clog2(GAMMA_CYCLE_LENGTH);

    typedef logic [P-1:0][VRES-1:0] value_vec_t;

    // Latest pulse (spiketime max + width) must end before the wave wraps.
    function automatic bit timing_fits(input int unsigned vres,
                                       input int unsigned pulse_width,
                                       input int unsigned gamma_len);
        return ((32'd1 << vres) + pulse_width) <= gamma_len;
    endfunction

endpackage

// File: rtl/gamma_sequencer.sv
// Gamma-wave position counter, grst pulse and wrap flag for the spike encoder.
// Optional SPIKE_ENC_ALT_GRST_EN adds the per-wave parity toggle on alt_grst.
module gamma_sequencer
    import spike_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rstb,
    output logic [CNT_W-1:0] cycle_counter,
    output logic [CNT_W-1:0] cnt_next,
    output logic             grst,
    output logic             wrap,
    output logic             alt_grst
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(GAMMA_CYCLE_LENGTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (rstb || (cnt_q == LastCnt)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_counter = cnt_q;
    assign cnt_next      = cnt_d;
    assign wrap          = (cnt_q == LastCnt);
    // Held low while in reset so the first grst lands on the release cycle.
    assign grst          = (cnt_q == '0) && !rstb;

`ifdef SPIKE_ENC_ALT_GRST_EN
    logic alt_q;

    always_ff @(posedge clk) begin
        if (rstb) begin
            alt_q <= 1'b0;
        end else if (wrap) begin
            alt_q <= ~alt_q;
        end
    end

    // Inverted so the first wave after reset reads 1.
    assign alt_grst = ~alt_q & ~rstb;
`else
    assign alt_grst = 1'b0;
`endif

endmodule

// File: rtl/spike_encoder.sv
// Temporal-encoding transmitter: buffers input vectors and emits one pulse per channel per wave.
// Optional SPIKE_ENC_ALT_GRST_EN enables the wave-parity output alt_grst.
module spike_encoder
    import spike_enc_pkg::*;
(
    input  logic             clk,
    input  logic             rstb,
    input  logic             in_valid,
    output logic             in_ready,
    input  value_vec_t       in_values,
    input  logic [P-1:0]     in_nospike,
    output logic [P-1:0]     input_spikes,
    output logic             grst,
    output logic [CNT_W-1:0] cycle_counter,
    output logic             wave_active,
    output logic             alt_grst
);

    if (!timing_fits(VRES, PULSE_WIDTH, GAMMA_CYCLE_LENGTH)) begin : g_timing_check
        $error("spike_encoder: (1<<VRES)+PULSE_WIDTH exceeds GAMMA_CYCLE_LENGTH");
    end

    logic [CNT_W-1:0] cnt_next;
    logic             wrap;
    logic             xfer;

    logic             hold_valid_q, hold_valid_d;
    value_vec_t       hold_vals_q, hold_vals_d;
    logic [P-1:0]     hold_nosp_q, hold_nosp_d;
    value_vec_t       act_vals_q, act_vals_d;
    logic [P-1:0]     act_nosp_q, act_nosp_d;
    logic             wave_active_q, wave_active_d;
    logic [P-1:0]     spikes_q, spikes_d;

    gamma_sequencer u_gamma_sequencer (
        .clk           (clk),
        .rstb          (rstb),
        .cycle_counter (cycle_counter),
        .cnt_next      (cnt_next),
        .grst          (grst),
        .wrap          (wrap),
        .alt_grst      (alt_grst)
    );

    assign in_ready = !hold_valid_q && !rstb;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_vals_d   = hold_vals_q;
        hold_nosp_d   = hold_nosp_q;
        act_vals_d    = act_vals_q;
        act_nosp_d    = act_nosp_q;
        wave_active_d = wave_active_q;
        if (wrap) begin
            if (hold_valid_q) begin
                act_vals_d    = hold_vals_q;
                act_nosp_d    = hold_nosp_q;
                wave_active_d = 1'b1;
                hold_valid_d  = 1'b0;
            end else if (xfer) begin
                // Bypass: holding is empty, so the vector goes straight to the next wave.
                act_vals_d    = in_values;
                act_nosp_d    = in_nospike;
                wave_active_d = 1'b1;
            end else begin
                wave_active_d = 1'b0;
            end
        end else if (xfer) begin
            hold_vals_d  = in_values;
            hold_nosp_d  = in_nospike;
            hold_valid_d = 1'b1;
        end
    end

    // Compared against the next count so the registered edge lines up with cycle_counter.
    always_comb begin : spike_cmp
        int unsigned lo;
        int unsigned nxt;
        spikes_d = '0;
        nxt      = 32'(cnt_next);
        for (int i = 0; i < P; i++) begin
            lo          = 32'(act_vals_q[i]) + 32'd1;
            spikes_d[i] = wave_active_q && !act_nosp_q[i] &&
                          (nxt >= lo) && (nxt < lo + PULSE_WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            hold_valid_q  <= 1'b0;
            hold_vals_q   <= '0;
            hold_nosp_q   <= '0;
            act_vals_q    <= '0;
            act_nosp_q    <= '0;
            wave_active_q <= 1'b0;
            spikes_q      <= '0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_vals_q   <= hold_vals_d;
            hold_nosp_q   <= hold_nosp_d;
            act_vals_q    <= act_vals_d;
            act_nosp_q    <= act_nosp_d;
            wave_active_q <= wave_active_d;
            spikes_q      <= spikes_d;
        end
    end

    assign wave_active  = wave_active_q;
    assign input_spikes = spikes_q;

endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
- Temporal-encoding transmitter that feeds a TNN column.
- Accepts P binary input values over a valid/ready handshake and buffers one vector.
- On each gamma wave it emits one pulse per channel, PULSE_WIDTH cycles wide, with rising edge at spiketime value+1.
- Also generates the gamma-cycle counter and the 1-cycle grst pulse the column consumes.

Parameters:
- P, 64, number of input channels (column synapses)
- VRES, 3, bit resolution of each input value (spiketime 0..2^VRES-1)
- PULSE_WIDTH, 8, spike pulse width in clk cycles (wmax+1)
- GAMMA_CYCLE_LENGTH, 18, clk cycles per gamma wave

Ports:
- clk  input  1  unit clock
- rstb  input  1  synchronous reset, active-high
- in_valid  input  1  input vector valid
- in_ready  output  1  encoder can accept a vector
- in_values  input  P*VRES  packed [P-1:0][VRES-1:0] spiketime per channel
- in_nospike  input  P  per-channel mask; 1 = channel stays silent this wave
- input_spikes  output  P  encoded pulses to column
- grst  output  1  1-cycle pulse at start of each wave
- cycle_counter  output  $clog2(GAMMA_CYCLE_LENGTH)  position within the current wave
- wave_active  output  1  current wave carries an accepted vector
- alt_grst  output  1  wave-parity toggle (see Optional Feature)

Behaviour:
- Elaboration check: (1<<VRES)+PULSE_WIDTH must be <= GAMMA_CYCLE_LENGTH; otherwise $error. Defaults give 16 <= 18.
- Reset (rstb=1), applied on the same edge:
  - all outputs 0; cycle_counter=0; holding and active buffers invalid.
  - A wave in flight is abandoned. No partial pulse appears after reset.
- Gamma sequencer:
  - Counter runs 0..GAMMA_CYCLE_LENGTH-1, wraps to 0, free-running after reset.
  - First cycle after reset release: cycle_counter=0 and grst=1.
  - grst=1 exactly when cycle_counter==0.
- Buffering: two registers, holding (1 entry) and active (current wave).
  - in_ready = !hold_valid && !rstb.
  - A transfer (in_valid && in_ready) captures in_values and in_nospike into holding.
  - in_values must stay stable only in the transfer cycle.
- Wave boundary (cycle_counter==GAMMA_CYCLE_LENGTH-1):
  - If hold_valid: active <= holding, hold_valid <= 0, wave_active <= 1 for the next wave.
  - Else, if a transfer occurs in this same cycle: bypass; the vector loads directly into active and holding stays empty.
  - Else: the next wave is idle, with wave_active=0 and all input_spikes 0.
- Throughput: at most one vector per wave. Two vectors can be outstanding (active plus holding).
- Pulse generation: input_spikes is registered.
  - input_spikes[i]=1 for every cycle in which cycle_counter lies in [v_i+1, v_i+PULSE_WIDTH], with v_i = active value of channel i.
  - Requires wave_active=1 and in_nospike_i=0.
  - Generation is computed from the next-count value so the edge aligns exactly with cycle_counter.
  - Every pulse is exactly PULSE_WIDTH cycles and ends before the wrap.
- wave_active and active contents hold constant across the whole wave. They change only at the boundary edge.

Optional Feature:
- Macro: SPIKE_ENC_ALT_GRST_EN
- Defined: alt_grst toggles on the edge where cycle_counter goes to 0, so it is constant within a wave.
  - Reset value 0; the first wave after reset has alt_grst=1.
  - Purpose: selects the weight bank in the multiplexed column.
- Undefined: alt_grst tied to 0; the toggle register is not synthesized.

Decomposition:
- Package spike_enc_pkg holds:
  - localparam CNT_W = $clog2(GAMMA_CYCLE_LENGTH)
  - typedef of the value vector, logic [P-1:0][VRES-1:0]
  - the elaboration-check function
- Sub-module gamma_sequencer: counter, grst, wrap flag, alt_grst toggle.
- Buffering and pulse comparators stay in spike_encoder.

Test Plan:
- Reset release → cycle_counter=0 with grst=1 on the first cycle; grst recurs every 18 cycles; input_spikes=0 and wave_active=0 until a vector is loaded.
- Accept a vector with ch0=0, ch1=7, ch2=3 before the boundary → next wave has:
  - ch0 high at counts 1..8
  - ch1 high at counts 8..15
  - ch2 high at counts 4..11
  - each exactly 8 cycles
- Transfer exactly at cycle_counter=17 with holding empty → bypass; spikes appear in the immediately following wave; in_ready stays 1.
- Hold in_valid=1 continuously → two vectors accepted, then in_ready=0 until each boundary frees holding; one vector per 18 cycles; no vector lost or duplicated.
- in_nospike=0x1 with ch0=2 → ch0 silent for the whole wave; other channels unaffected. Idle wave (no vector) → all zeros, wave_active=0.
- rstb asserted at cycle_counter=9 mid-pulse → input_spikes=0 on the next cycle, buffers cleared; after release a fresh wave starts at count 0. With SPIKE_ENC_ALT_GRST_EN defined, alt_grst = 1,0,1 over three consecutive waves.
